// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run/trace controller: FSM state and halt cause.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    HC_NONE  = 2'd0,
    HC_LIMIT = 2'd1,
    HC_BP    = 2'd2,
    HC_ABORT = 2'd3
  } halt_cause_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port and a registered read port. The array is
// never reset; only the read register is.
module trace_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Nonblocking read of the same address as a write returns the old entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/run_trace_controller.sv
// Run controller for a core: reset/run/halt sequencing, breakpoint, cycle
// limit, single-step and a circular trace of executed {pc, alu_result}.
module run_trace_controller
  import run_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int CYCLE_W     = 16,
  parameter int RST_CYCLES  = 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           start,
  input  logic                           resume,
  input  logic                           step,
  input  logic                           abort,
  input  logic [CYCLE_W-1:0]             max_cycles,
  input  logic                           bp_en,
  input  logic [DATA_W-1:0]              bp_addr,
  input  logic [DATA_W-1:0]              pc,
  input  logic [DATA_W-1:0]              alu_result,
  output logic                           core_rst,
  output logic                           core_en,
  output logic [1:0]                     state,
  output logic [CYCLE_W-1:0]             cycle_count,
  output logic                           done,
  output logic [1:0]                     halt_cause,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [DATA_W-1:0]              trace_rd_pc,
  output logic [DATA_W-1:0]              trace_rd_alu,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

  localparam int IDX_W = $clog2(TRACE_DEPTH);
  localparam int TC_W  = IDX_W + 1;
  localparam int RCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  run_state_t       cur, nxt;
  halt_cause_t      cause_q, cause_now;
  logic [RCW-1:0]   rst_cnt;
  logic             skip_bp;
  logic             en, enter_reset, go_halt, go_resume;
  logic [IDX_W-1:0] wr_ptr, oldest, rd_addr;
  logic [2*DATA_W-1:0] rd_data;

  always_comb begin
    nxt         = cur;
    en          = 1'b0;
    enter_reset = 1'b0;
    go_halt     = 1'b0;
    go_resume   = 1'b0;
    cause_now   = HC_NONE;
    if (abort)                                          cause_now = HC_ABORT;
    else if (bp_en && (pc == bp_addr) && !skip_bp)      cause_now = HC_BP;
    else if ((max_cycles != '0) && (cycle_count == max_cycles)) cause_now = HC_LIMIT;
    case (cur)
      ST_IDLE: begin
        if (start) begin nxt = ST_RESET; enter_reset = 1'b1; end
      end
      ST_RESET: begin
        if (start)                                   enter_reset = 1'b1;
        else if (rst_cnt == RCW'(RST_CYCLES - 1))    nxt = ST_RUN;
      end
      ST_RUN: begin
        en = (cause_now == HC_NONE);
        if (start)    begin nxt = ST_RESET; enter_reset = 1'b1; end
        else if (!en) begin nxt = ST_HALT;  go_halt = 1'b1; end
      end
      ST_HALT: begin
        // start beats resume beats step; a held abort blocks resume and step
        if (start)                  begin nxt = ST_RESET; enter_reset = 1'b1; end
        else if (!abort && resume)  begin nxt = ST_RUN;   go_resume = 1'b1; end
        else if (!abort && step)    en = 1'b1;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign core_rst   = (cur == ST_IDLE) || (cur == ST_RESET);
  assign core_en    = en;
  assign state      = cur;
  assign halt_cause = cause_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur         <= ST_IDLE;
      rst_cnt     <= '0;
      skip_bp     <= 1'b0;
      cause_q     <= HC_NONE;
      done        <= 1'b0;
      cycle_count <= '0;
      wr_ptr      <= '0;
      trace_count <= '0;
    end else begin
      cur  <= nxt;
      done <= go_halt;
      if (enter_reset) begin
        rst_cnt     <= '0;
        skip_bp     <= 1'b0;
        cause_q     <= HC_NONE;
        cycle_count <= '0;
        wr_ptr      <= '0;
        trace_count <= '0;
      end else begin
        if (cur == ST_RESET) rst_cnt <= rst_cnt + 1'b1;
        if (go_resume)           skip_bp <= 1'b1;
        else if (cur == ST_RUN)  skip_bp <= 1'b0;
        if (go_halt) cause_q <= cause_now;
        if (en) begin
          cycle_count <= sat_inc(cycle_count);
          wr_ptr      <= wr_ptr + 1'b1;
          if (trace_count != TC_W'(TRACE_DEPTH)) trace_count <= trace_count + 1'b1;
        end
      end
    end
  end

  // Once full, the oldest entry is the one about to be overwritten.
  assign oldest  = trace_count[IDX_W] ? wr_ptr : '0;
  assign rd_addr = oldest + trace_rd_idx;

  trace_ram #(
    .DATA_W (2*DATA_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace_ram (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (en),
    .wr_addr (wr_ptr),
    .wr_data ({pc, alu_result}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign trace_rd_pc  = rd_data[2*DATA_W-1:DATA_W];
  assign trace_rd_alu = rd_data[DATA_W-1:0];

endmodule

// File: tb/tb_run_trace_controller.sv
// Bench for run_trace_controller: per-cycle scoreboard fed by a queue-based
// reference model of the run/halt rules and trace buffer.
module tb_run_trace_controller;

  localparam int DW = 32, TD = 16, CW = 16, RC = 1, IW = 4;
  localparam int S_IDLE = 0, S_RESET = 1, S_RUN = 2, S_HALT = 3;

  logic          CLK = 1'b0, RST = 1'b0;
  logic          start = 0, resume = 0, step = 0, abort = 0, bp_en = 0;
  logic [CW-1:0] max_cycles = '0;
  logic [DW-1:0] bp_addr = '0, pc = '0, alu_result = '0;
  logic          core_rst, core_en, done;
  logic [1:0]    state, halt_cause;
  logic [CW-1:0] cycle_count;
  logic [IW-1:0] trace_rd_idx = '0;
  logic [DW-1:0] trace_rd_pc, trace_rd_alu;
  logic [IW:0]   trace_count;

  always #5 CLK = ~CLK;

  run_trace_controller #(.DATA_W(DW), .TRACE_DEPTH(TD), .CYCLE_W(CW), .RST_CYCLES(RC)) dut (
    .CLK(CLK), .RST(RST), .start(start), .resume(resume), .step(step), .abort(abort),
    .max_cycles(max_cycles), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .alu_result(alu_result), .core_rst(core_rst), .core_en(core_en), .state(state),
    .cycle_count(cycle_count), .done(done), .halt_cause(halt_cause),
    .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc), .trace_rd_alu(trace_rd_alu),
    .trace_count(trace_count)
  );

  typedef struct {
    logic [1:0] st; logic crst; logic cen; logic [CW-1:0] cnt;
    logic [1:0] cause; logic dn; logic [IW:0] tcnt;
  } exp_t;
  typedef struct { int cyc; logic [63:0] d; } rd_t;

  exp_t scq[$];
  rd_t  rdq[$];
  int   total = 0, bad = 0, cyc = 0;

  // reference model state
  int          m_state = S_IDLE, m_rcnt = 0, m_cause = 0;
  int unsigned m_cnt = 0;
  bit          m_done = 0, m_skip = 0;
  logic [31:0] m_pc = '0;
  logic [63:0] trace_q[$];

  logic [CW-1:0] c_mc = '0;
  bit            c_be = 0;
  logic [31:0]   c_ba = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial forever begin
    exp_t e;
    rd_t  r;
    @(negedge CLK);
    if (scq.size() > 0) begin
      e = scq.pop_front();
      chk("state", state, e.st);
      chk("core_rst", core_rst, e.crst);
      chk("core_en", core_en, e.cen);
      chk("cycle_count", cycle_count, e.cnt);
      chk("halt_cause", halt_cause, e.cause);
      chk("done", done, e.dn);
      chk("trace_count", trace_count, e.tcnt);
    end
    if (rdq.size() > 0 && rdq[0].cyc == cyc - 1) begin
      r = rdq.pop_front();
      chk("trace_rd", {trace_rd_pc, trace_rd_alu}, r.d);
    end
  end

  task automatic fresh();
    m_state = S_RESET; m_rcnt = 0; m_cnt = 0; m_cause = 0; m_skip = 0;
    trace_q.delete();
  endtask

  task automatic cycle(input bit s, input bit r, input bit sp, input bit ab,
                       input logic [CW-1:0] mc, input bit be, input logic [31:0] ba,
                       input int idx);
    exp_t        e;
    int          hc;
    bit          en;
    logic [31:0] alu;
    rd_t         rd;
    @(posedge CLK); #1;
    cyc++;
    alu = $urandom;
    start = s; resume = r; step = sp; abort = ab; max_cycles = mc;
    bp_en = be; bp_addr = ba; pc = m_pc; alu_result = alu; trace_rd_idx = idx[IW-1:0];
    hc = 0; en = 0;
    if (m_state == S_RUN) begin
      if (ab)                               hc = 3;
      else if (be && m_pc == ba && !m_skip) hc = 2;
      else if (mc != 0 && m_cnt == mc)      hc = 1;
      en = (hc == 0);
    end else if (m_state == S_HALT) begin
      en = !s && !r && sp && !ab;
    end
    e.st = m_state[1:0]; e.crst = (m_state == S_IDLE || m_state == S_RESET); e.cen = en;
    e.cnt = m_cnt[CW-1:0]; e.cause = m_cause[1:0]; e.dn = m_done;
    e.tcnt = (IW+1)'(trace_q.size());
    scq.push_back(e);
    if (idx < trace_q.size()) begin
      rd.cyc = cyc; rd.d = trace_q[idx];
      rdq.push_back(rd);
    end
    m_done = 0;
    if (en) begin
      trace_q.push_back({m_pc, alu});
      if (trace_q.size() > TD) void'(trace_q.pop_front());
      if (m_cnt != (1 << CW) - 1) m_cnt++;
      m_pc += 4;
    end
    if (m_state == S_IDLE || m_state == S_RESET) m_pc = '0;
    case (m_state)
      S_IDLE:  if (s) fresh();
      S_RESET: if (s) fresh(); else if (m_rcnt == RC - 1) m_state = S_RUN; else m_rcnt++;
      S_RUN: begin
        m_skip = 0;
        if (s) fresh();
        else if (hc != 0) begin m_state = S_HALT; m_cause = hc; m_done = 1; end
      end
      default: if (s) fresh(); else if (r && !ab) begin m_state = S_RUN; m_skip = 1; end
    endcase
  endtask

  task automatic pulse(input bit s, input bit r, input bit sp, input bit ab);
    cycle(s, r, sp, ab, c_mc, c_be, c_ba, $urandom_range(0, TD-1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) pulse(0, 0, 0, 0);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 64 == 0) begin
        c_mc = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(1, 40));
        c_be = $urandom_range(0, 1);
        c_ba = 4 * $urandom_range(0, 24);
      end
      pulse($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
    end
  endtask

  initial begin
    #2;
    chk("rst_state", state, S_IDLE);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_trace_count", trace_count, 0);
    chk("rst_rd_pc", trace_rd_pc, 0);
    #10 RST = 1'b1;

    // limit halt after 5 cycles
    c_mc = 5; c_be = 0;
    pulse(1, 0, 0, 0); run(10);
    @(negedge CLK);
    chk("lim_cnt", cycle_count, 5); chk("lim_cause", halt_cause, 1);
    chk("lim_state", state, S_HALT); chk("lim_tcnt", trace_count, 5);

    // three single steps in HALT
    pulse(0, 0, 1, 0); run(1); pulse(0, 0, 1, 0); pulse(0, 0, 1, 0); run(2);
    @(negedge CLK);
    chk("step_cnt", cycle_count, 8); chk("step_tcnt", trace_count, 8);
    chk("step_state", state, S_HALT);

    // breakpoint at 0x10, resume past it, then abort
    c_mc = 0; c_be = 1; c_ba = 32'h10;
    pulse(1, 0, 0, 0); run(8);
    @(negedge CLK);
    chk("bp_cnt", cycle_count, 4); chk("bp_cause", halt_cause, 2);
    pulse(0, 1, 0, 0); run(3); pulse(0, 0, 0, 1); run(2);
    @(negedge CLK);
    chk("ab_cnt", cycle_count, 7); chk("ab_cause", halt_cause, 3);
    pulse(0, 1, 0, 1); run(1);
    @(negedge CLK);
    chk("ab_resume_blocked", state, S_HALT);

    // abort and breakpoint together
    c_ba = 32'h8;
    pulse(1, 0, 0, 0); run(3); pulse(0, 0, 0, 1); run(1);
    @(negedge CLK);
    chk("abbp_cause", halt_cause, 3); chk("abbp_cnt", cycle_count, 2);

    // breakpoint on the very first RUN cycle
    c_ba = 32'h0;
    pulse(1, 0, 0, 0); run(3);
    @(negedge CLK);
    chk("bp0_cause", halt_cause, 2); chk("bp0_cnt", cycle_count, 0);

    // wrap: 20 cycles into a 16-entry trace
    c_be = 0; c_mc = 20;
    pulse(1, 0, 0, 0); run(24);
    @(negedge CLK);
    chk("wrap_cnt", cycle_count, 20); chk("wrap_tcnt", trace_count, 16);
    cycle(0, 0, 0, 0, c_mc, c_be, c_ba, 0);
    @(negedge CLK); @(negedge CLK);
    chk("wrap_idx0_pc", trace_rd_pc, 32'h10);
    cycle(0, 0, 0, 0, c_mc, c_be, c_ba, 15);
    @(negedge CLK); @(negedge CLK);
    chk("wrap_idx15_pc", trace_rd_pc, 32'h4C);

    rand_phase(2500);

    // asynchronous reset in the middle of a run
    c_mc = 0; c_be = 0;
    pulse(1, 0, 0, 0); run(6);
    @(negedge CLK); #2;
    RST = 1'b0;
    scq.delete(); rdq.delete();
    #1;
    chk("arst_state", state, S_IDLE); chk("arst_core_rst", core_rst, 1);
    chk("arst_core_en", core_en, 0); chk("arst_cnt", cycle_count, 0);
    chk("arst_done", done, 0); chk("arst_cause", halt_cause, 0);
    chk("arst_tcnt", trace_count, 0); chk("arst_rd_pc", trace_rd_pc, 0);
    chk("arst_rd_alu", trace_rd_alu, 0);
    @(posedge CLK); #1;
    chk("arst_done_hold", done, 0); chk("arst_state_hold", state, S_IDLE);
    start = 0; resume = 0; step = 0; abort = 0;
    m_state = S_IDLE; m_rcnt = 0; m_cnt = 0; m_cause = 0; m_done = 0; m_skip = 0;
    m_pc = '0; trace_q.delete();
    #3 RST = 1'b1;

    rand_phase(300);
    @(negedge CLK); @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_trace_controller.md
RUN_TRACE_CONTROLLER -- requirements
Module: run_trace_controller

Interface
REQ-001 Parameter DATA_W, 32, width of the pc and alu_result fields.
REQ-002 Parameter TRACE_DEPTH, 16, number of trace entries; power of two, at least 2.
REQ-003 Parameter CYCLE_W, 16, width of the cycle counter and of max_cycles.
REQ-004 Parameter RST_CYCLES, 1, number of cycles core_rst is held per run; at least 1.
REQ-005 CLK  in  1  single clock; all state changes on the rising edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  pulse; begin a fresh run.
REQ-008 resume  in  1  pulse; continue from HALT.
REQ-009 step  in  1  pulse; execute one core cycle while in HALT.
REQ-010 abort  in  1  level; force HALT.
REQ-011 max_cycles  in  CYCLE_W  run limit; 0 means unlimited.
REQ-012 bp_en  in  1  enables the breakpoint.
REQ-013 bp_addr  in  DATA_W  breakpoint PC.
REQ-014 pc  in  DATA_W  core program counter.
REQ-015 alu_result  in  DATA_W  core ALU result.
REQ-016 core_rst  out  1  active-high reset to the core.
REQ-017 core_en  out  1  core clock enable.
REQ-018 state  out  2  encoding: IDLE=0, RESET=1, RUN=2, HALT=3.
REQ-019 cycle_count  out  CYCLE_W  number of executed core cycles.
REQ-020 done  out  1  one-cycle pulse on entry to HALT.
REQ-021 halt_cause  out  2  encoding: NONE=0, LIMIT=1, BP=2, ABORT=3.
REQ-022 trace_rd_idx  in  log2(TRACE_DEPTH)  read index; 0 is the oldest retained entry.
REQ-023 trace_rd_pc, trace_rd_alu  out  DATA_W each  registered read data.
REQ-024 trace_count  out  log2(TRACE_DEPTH)+1  number of valid trace entries.

Function
REQ-025 IDLE: core_rst=1, core_en=0; start moves the FSM to RESET.
REQ-026 RESET: core_rst=1 for exactly RST_CYCLES cycles, then RUN; on entry, clear cycle_count, trace_count, write pointer and halt_cause.
REQ-027 RUN: core_rst=0; core_en=1 each cycle unless a halt condition holds that cycle (combinational).
REQ-028 Each enabled cycle: write {pc, alu_result} into the trace; increment cycle_count, saturating at all-ones.
REQ-029 Halt conditions, priority ABORT > BP > LIMIT:
- ABORT: abort=1.
- BP: bp_en=1 and pc==bp_addr; the breakpointed instruction is not executed.
- LIMIT: max_cycles!=0 and cycle_count==max_cycles.
REQ-030 On a halt condition: core_en=0 that cycle, next state HALT, halt_cause latched, done pulses one cycle.
REQ-031 The first RUN cycle after resume ignores BP, so a run can continue past the breakpointed PC.
REQ-032 BP matching pc at the first RUN cycle (e.g. bp_addr=0) halts with cycle_count=0.
REQ-033 HALT: core_rst=0, core_en=0.
- step: exactly one enabled cycle (traced, counted) while remaining in HALT; BP and LIMIT are ignored; halt_cause unchanged.
- resume with abort=0: move to RUN.
- start: move to RESET (fresh run).
REQ-034 Priority of inputs arriving in the same cycle in HALT: start > resume > step; abort=1 blocks resume and step.
REQ-035 start during RUN or RESET restarts RESET; step and resume in IDLE, RESET or RUN are ignored.
REQ-036 Trace buffer: circular; the write pointer wraps modulo TRACE_DEPTH and trace_count saturates at TRACE_DEPTH.
REQ-037 Trace read: entry (oldest + trace_rd_idx) mod TRACE_DEPTH; 1-cycle latency; read data is undefined for idx >= trace_count.
REQ-038 A read and a write to the same entry in one cycle returns the old data.

Reset
REQ-039 RST=0 asynchronously forces: state=IDLE, core_rst=1, core_en=0, cycle_count=0, done=0, halt_cause=NONE, trace_count=0, write pointer=0, trace_rd_pc=0, trace_rd_alu=0.
REQ-040 Trace storage contents are not reset.
REQ-041 Reset asserted mid-run takes effect immediately; no done pulse is generated.

Structure
REQ-042 State and halt_cause encodings belong in the shared package run_ctrl_pkg.
REQ-043 The trace storage is one sub-module, trace_ram: single write port, registered read port, no reset on the array.

Verification
REQ-044 start, max_cycles=5, bp_en=0 -> core_rst high 1 cycle; 5 enabled cycles; HALT; halt_cause=LIMIT; done one pulse; cycle_count=5; trace_count=5.
REQ-045 bp_en=1, bp_addr=0x10, core pc steps by 4 from 0 -> halt with pc=0x10 and cycle_count=4; resume -> 0x10 executes; next halt by LIMIT or abort.
REQ-046 In HALT, three step pulses -> cycle_count +3, trace_count +3, state stays HALT, done does not pulse.
REQ-047 TRACE_DEPTH=16, 20 cycles run -> trace_count=16; idx 0 returns the pc of cycle 5; idx 15 returns the pc of cycle 20.
REQ-048 abort and bp match in the same RUN cycle -> halt_cause=ABORT; resume ignored while abort=1.
REQ-049 RST low mid-RUN -> all outputs at reset values in the same cycle (asynchronous); no done pulse.
